mem_arbiter: RTL
================

# mem_arbiter

Sequential arbiter that lets the multi-cycle CPU's instruction-fetch path and its load/store path share one single-port, fixed-latency memory. It serialises requests: exactly one transaction is in flight at a time. Data requests normally win over fetch, with a starvation guard so fetch is never blocked indefinitely. It sits between the CPU top (fetch address, `mem_load`/`mem_store`, ALU result as data address, store data) and the unified memory macro.

## Interface
- `MEM_LAT`, default 2: memory read latency in cycles, legal range ≥1. `mem_rdata` is valid `MEM_LAT` cycles after the cycle in which `mem_en` is high.
- `DATA_BURST_MAX`, default 2: maximum consecutive data grants allowed while `if_req` is pending.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  32  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` is valid.
- `if_rdata`  out  32  fetched instruction (registered, held).
- `d_req`  in  1  data request (load or store); held until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  one-cycle pulse: load data valid, or store complete.
- `d_rdata`  out  32  load data (registered, held; unchanged by stores).
- `mem_en`  out  1  memory access strobe, one cycle per transaction.
- `mem_we`  out  1  memory write enable, valid with `mem_en`.
- `mem_addr`  out  32  memory address (registered, held).
- `mem_wdata`  out  32  memory write data (registered, held).
- `mem_rdata`  in  32  memory read data.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: accept a request.
  - ISSUE: `mem_en`=1 for one cycle.
  - WAIT: latency counter running.
  - Return to IDLE on response.
- IDLE arbitration, when at least one request is present:
  - `d_req` only: grant data.
  - `if_req` only: grant fetch.
  - Both: grant data, unless `dcnt` == `DATA_BURST_MAX`, in which case grant fetch.
- `dcnt` (starvation counter):
  - Increments on each data grant made while `if_req`=1.
  - Clears on any fetch grant, and whenever `if_req`=0 in IDLE.
  - Saturates at `DATA_BURST_MAX`.
- Grant conditions:
  - `gnt` is asserted only in IDLE, only for the winner, and only in the same cycle as the `req` it answers.
  - Requests in any non-IDLE state are ignored and their `gnt` stays 0.
  - At the granting edge, the arbiter registers `mem_addr`, `mem_we` (0 for fetch, `d_we` for data), `mem_wdata` (only for a data store; otherwise held), and an owner flag. It then moves to ISSUE.
- ISSUE → WAIT: the counter is loaded with `MEM_LAT`-1.
  - If `MEM_LAT`=1, the counter starts at 0.
- WAIT:
  - Counter ≠ 0: decrement.
  - Counter = 0: `mem_rdata` is valid this cycle. Capture it into the owner's rdata register (not for stores) and go to IDLE.
- In the IDLE cycle after capture, the owner's `rvalid` pulses for exactly one cycle. A new grant may occur in that same cycle.
- Stores complete through the same path: `d_rvalid` pulses, and `d_rdata` is unchanged.
- The response for one requester never touches the other requester's `rdata`/`rvalid`.

## Timing
- Reset values:
  - All outputs are 0: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_en`, `mem_we`, `busy`.
  - `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` are all 0.
  - State is IDLE and `dcnt` is 0.
- Reset mid-transaction: immediately abort, with no `rvalid` pulse. The in-flight `mem_rdata` is discarded, and the rdata registers are cleared to 0.
- Latency, with grant in cycle G:
  - `mem_en` is high in G+1.
  - Capture happens in G+1+`MEM_LAT`.
  - `rvalid` pulses in G+2+`MEM_LAT`.
  - Total: `MEM_LAT`+2 cycles from grant to `rvalid`.
- Throughput: back-to-back transactions have grants spaced `MEM_LAT`+2 cycles apart.
- `busy`=1 from G+1 through the capture cycle, inclusive.
- `mem_addr`/`mem_wdata`/`mem_we` hold their last values when `mem_en`=0.
- `mem_we` is valid only while `mem_en`=1.

## Test plan
- Single fetch, `MEM_LAT`=2:
  - Stimulus: `if_req`=1, `if_addr`=0x10 in cycle 3, memory returns 0xDEADBEEF.
  - Required: `if_gnt`=1 in cycle 3, `mem_en`=1 with `mem_addr`=0x10 and `mem_we`=0 in cycle 4, `if_rvalid`=1 with `if_rdata`=0xDEADBEEF in cycle 7.
- Store:
  - Stimulus: `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0x1234.
  - Required: `mem_we`=1 and `mem_wdata`=0x1234 on the `mem_en` cycle, `d_rvalid` pulses 4 cycles after `d_gnt`, `d_rdata` is unchanged.
- Simultaneous requests:
  - Stimulus: `if_req` and `d_req` both held high continuously, `DATA_BURST_MAX`=2.
  - Required: grant order is D, D, F, D, D, F, and no grant occurs while `busy`=1.
- `MEM_LAT`=1 load:
  - Stimulus: `mem_rdata`=0xA5A5A5A5.
  - Required: `d_rvalid` is exactly 3 cycles after `d_gnt`, with `d_rdata`=0xA5A5A5A5.
- Reset asserted in WAIT during a fetch:
  - Required: outputs are 0 asynchronously, no `if_rvalid` pulse occurs, and `if_rdata`=0.
  - After release, a new `d_req` is granted in the first IDLE cycle.
- Request during `busy`:
  - Stimulus: `d_req` raised in the ISSUE cycle of a fetch.
  - Required: `d_gnt`=0 until the cycle `if_rvalid` pulses, then `d_gnt`=1 in that same cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, fixed-latency memory between the CPU's instruction
// fetch path and its load/store path. Exactly one transaction is in flight at
// a time. Data normally wins over fetch, but after DATA_BURST_MAX consecutive
// data grants with a fetch waiting, the fetch is granted next.
//
// Parameters
//   MEM_LAT         memory read latency in cycles (>= 1)
//   DATA_BURST_MAX  consecutive data grants allowed while if_req is pending
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   if_req/if_addr  fetch request / address; if_gnt combinational accept
//   if_rvalid       one-cycle pulse, if_rdata holds the fetched word
//   d_req/d_we      data request, 1 = store / 0 = load
//   d_addr/d_wdata  data address / store data; d_gnt combinational accept
//   d_rvalid        one-cycle pulse: load data valid or store complete
//   d_rdata         load data (held, untouched by stores)
//   mem_*           memory strobe, write enable, address, write data, read data
//   busy            high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT        = 2,
    parameter int DATA_BURST_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int DW = (DATA_BURST_MAX > 0) ? $clog2(DATA_BURST_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [DW-1:0] dcnt_reg;
    logic          owner_d_reg;   // 1 = current transaction belongs to data path
    logic          mem_we_reg;    // doubles as "current transaction is a store"
    logic          if_rvalid_reg, d_rvalid_reg;
    logic [31:0]   if_rdata_reg, d_rdata_reg, mem_addr_reg, mem_wdata_reg;
    logic          grant_d, grant_f, capture, burst_full;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and arbitration
    always_comb begin
        state_next = state_reg;
        grant_d    = 1'b0;
        grant_f    = 1'b0;
        capture    = 1'b0;
        burst_full = (dcnt_reg == DW'(DATA_BURST_MAX));
        case (state_reg)
            S_IDLE: begin
                // Data wins unless a fetch has already waited through a full burst
                if (d_req && !(if_req && burst_full)) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_f = 1'b1;
                end
                if (grant_d || grant_f) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                // Counter reaching zero marks the cycle mem_rdata is valid
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, latency counter and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            dcnt_reg      <= '0;
            owner_d_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
        end else begin
            if_rvalid_reg <= capture && !owner_d_reg;
            d_rvalid_reg  <= capture && owner_d_reg;

            if (grant_d || grant_f) begin
                mem_addr_reg <= grant_d ? d_addr : if_addr;
                mem_we_reg   <= grant_d && d_we;
                owner_d_reg  <= grant_d;
                if (grant_d && d_we) begin
                    mem_wdata_reg <= d_wdata;
                end
            end

            if (state_reg == S_ISSUE) begin
                cnt_reg <= CW'(MEM_LAT - 1);
            end else if (state_reg == S_WAIT && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CW'(1);
            end

            // Stores complete through the same path but leave d_rdata alone
            if (capture) begin
                if (!owner_d_reg) begin
                    if_rdata_reg <= mem_rdata;
                end else if (!mem_we_reg) begin
                    d_rdata_reg <= mem_rdata;
                end
            end

            if (state_reg == S_IDLE) begin
                if (!if_req || grant_f) begin
                    dcnt_reg <= '0;
                end else if (grant_d && !burst_full) begin
                    dcnt_reg <= dcnt_reg + DW'(1);
                end
            end
        end
    end

    assign if_gnt    = grant_f;
    assign d_gnt     = grant_d;
    assign if_rvalid = if_rvalid_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_en    = (state_reg == S_ISSUE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule
